alu_seq_ctrl: RTL and testbench
===============================

ALU_SEQ_CTRL -- requirements
Module: alu_seq_ctrl

Interface
REQ-001 SHALL have parameter DW, default 8, operand/result width.
REQ-002 SHALL have parameter AW, default 2, register-file address width (4 entries).
REQ-003 SHALL have port clk, input, 1, single clock; all state on rising edge.
REQ-004 SHALL have port rst, input, 1, asynchronous active-high reset.
REQ-005 SHALL have ports cmd_valid in 1, cmd_ready out 1: command handshake.
REQ-006 SHALL have ports cmd_op in 3, cmd_rd/cmd_rs1/cmd_rs2 in AW each, cmd_rep in 2: opcode, destination, sources, repeat count.
REQ-007 SHALL have ports rf_raddr_a/rf_raddr_b out AW, rf_rdata_a/rf_rdata_b in DW: combinational register-file reads.
REQ-008 SHALL have ports rf_we out 1, rf_waddr out AW, rf_wdata out DW: register-file write.
REQ-009 SHALL have ports alu_a/alu_b out DW, alu_op out 3, alu_y in DW: combinational ALU.
REQ-010 SHALL have ports rsp_valid out 1, rsp_ready in 1, rsp_data out DW, rsp_zero out 1, rsp_err out 1, busy out 1.

Function
REQ-011 SHALL implement FSM states IDLE, READ, EXEC, WB, DONE.
REQ-012 SHALL drive cmd_ready=1 only in IDLE; cmd_valid&cmd_ready latches op, rd, rs1, rs2, rep and moves to READ.
REQ-013 SHALL in READ drive rf_raddr_a=rs1 (first iteration) or rd (later iterations), rf_raddr_b=rs2, registering both rdata values; next EXEC.
REQ-014 SHALL in EXEC drive alu_a/alu_b from registered operands and alu_op=op, registering alu_y as result; next WB.
REQ-015 SHALL in WB assert rf_we for exactly one cycle with rf_waddr=rd, rf_wdata=result; rf_we=0 in every other state.
REQ-016 SHALL after WB go to READ with rep decremented if rep!=0, else to DONE.
REQ-017 SHALL in DONE hold rsp_valid=1, rsp_data=result, rsp_zero=(result==0) stable until rsp_ready; on handshake go to IDLE.
REQ-018 SHALL give latency: accept at edge k -> rsp_valid high from cycle k+4 for rep=0; each further iteration adds 3 cycles.
REQ-019 SHALL drive busy=1 in every state except IDLE.
REQ-020 SHALL with rsp_ready held high return to IDLE one cycle after DONE; no command accepted while in DONE.
REQ-021 SHALL drive alu_*/rf_raddr_* to 0 outside READ/EXEC.
REQ-022 SHALL use op codes 0 ADD, 1 SUB, 2 AND, 3 OR, 4 XOR, 5 PASS A, 6-7 reserved; ALU results wrap modulo 2^DW.

Reset
REQ-023 SHALL on rst asynchronously enter IDLE, clear all latched fields and result, force rf_we=0, rsp_valid=0, rsp_data=0, rsp_zero=0, rsp_err=0, busy=0; cmd_ready=1 after release.
REQ-024 SHALL on rst mid-operation (including during WB) abort with no further write and no response.

Configuration
REQ-025 SHALL support macro ALU_SEQ_ERR_CHK_EN: when defined, reserved op 6/7 goes READ->DONE skipping EXEC/WB (no write), rsp_err=1, rsp_data=0, rsp_zero=1; when undefined, reserved ops sequence normally to the ALU and rsp_err is tied 0.

Verification
REQ-026 SHALL verify: reset then ADD rd=2 rs1=0(5) rs2=1(3) rep=0 -> rf_we once, waddr 2 wdata 8, rsp_valid at k+4, rsp_data 8, rsp_zero 0.
REQ-027 SHALL verify: SUB rd=3 rs1=0(7) rs2=1(7) -> wdata 0, rsp_zero 1.
REQ-028 SHALL verify: ADD rd=2 rs1=0(250) rs2=1(10) rep=2 -> three writes to reg 2: 4, 14, 24 (wrap); rsp_data 24 at k+10.
REQ-029 SHALL verify: rsp_ready low 5 cycles in DONE -> rsp_valid/rsp_data stable, cmd_ready 0, second cmd_valid not accepted until after response handshake.
REQ-030 SHALL verify: rst pulse in EXEC -> rf_we never asserted, outputs at reset values immediately, busy 0.
REQ-031 SHALL verify: op 7 with ALU_SEQ_ERR_CHK_EN -> no rf_we, rsp_err 1, rsp_data 0; without macro -> one write, rsp_err 0.

Source files
------------

// File: rtl/alu_seq_ctrl.sv
// alu_seq_ctrl: sequences one ALU command at a time against an external
// register file and ALU: READ operands, EXECute, Write Back, optionally
// repeat using the destination as the new first operand, then hold a response.
// Optional build macro: ALU_SEQ_ERR_CHK_EN (reserved ops 6/7 report an error
// and skip EXEC/WB).
module alu_seq_ctrl #(
  parameter int DW = 8,
  parameter int AW = 2
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          cmd_valid,
  output logic          cmd_ready,
  input  logic [2:0]    cmd_op,
  input  logic [AW-1:0] cmd_rd,
  input  logic [AW-1:0] cmd_rs1,
  input  logic [AW-1:0] cmd_rs2,
  input  logic [1:0]    cmd_rep,
  output logic [AW-1:0] rf_raddr_a,
  output logic [AW-1:0] rf_raddr_b,
  input  logic [DW-1:0] rf_rdata_a,
  input  logic [DW-1:0] rf_rdata_b,
  output logic          rf_we,
  output logic [AW-1:0] rf_waddr,
  output logic [DW-1:0] rf_wdata,
  output logic [DW-1:0] alu_a,
  output logic [DW-1:0] alu_b,
  output logic [2:0]    alu_op,
  input  logic [DW-1:0] alu_y,
  output logic          rsp_valid,
  input  logic          rsp_ready,
  output logic [DW-1:0] rsp_data,
  output logic          rsp_zero,
  output logic          rsp_err,
  output logic          busy
);

  typedef enum logic [2:0] {
    IDLE,
    READ,
    EXEC,
    WB,
    DONE
  } state_t;

  state_t        state;
  logic [2:0]    op_q;
  logic [AW-1:0] rd_q;
  logic [AW-1:0] rs2_q;
  logic [1:0]    rep_q;
  logic [DW-1:0] result_q;

`ifdef ALU_SEQ_ERR_CHK_EN
  logic err_q;
  assign rsp_err = err_q;
`else
  assign rsp_err = 1'b0;
`endif

  // Single FSM; every output is registered and set on the transition into the state that owns it.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      op_q       <= '0;
      rd_q       <= '0;
      rs2_q      <= '0;
      rep_q      <= '0;
      result_q   <= '0;
      cmd_ready  <= 1'b1;
      rf_raddr_a <= '0;
      rf_raddr_b <= '0;
      rf_we      <= 1'b0;
      rf_waddr   <= '0;
      rf_wdata   <= '0;
      alu_a      <= '0;
      alu_b      <= '0;
      alu_op     <= '0;
      rsp_valid  <= 1'b0;
      rsp_data   <= '0;
      rsp_zero   <= 1'b0;
      busy       <= 1'b0;
`ifdef ALU_SEQ_ERR_CHK_EN
      err_q      <= 1'b0;
`endif
    end else begin
      rf_we <= 1'b0;
      case (state)
        IDLE: begin
          if (cmd_valid && cmd_ready) begin
            op_q       <= cmd_op;
            rd_q       <= cmd_rd;
            rs2_q      <= cmd_rs2;
            rep_q      <= cmd_rep;
            rf_raddr_a <= cmd_rs1;
            rf_raddr_b <= cmd_rs2;
            cmd_ready  <= 1'b0;
            busy       <= 1'b1;
            state      <= READ;
          end
        end
        READ: begin
          rf_raddr_a <= '0;
          rf_raddr_b <= '0;
`ifdef ALU_SEQ_ERR_CHK_EN
          if (op_q[2:1] == 2'b11) begin
            result_q  <= '0;
            rsp_valid <= 1'b1;
            rsp_data  <= '0;
            rsp_zero  <= 1'b1;
            err_q     <= 1'b1;
            state     <= DONE;
          end else begin
`else
          begin
`endif
            alu_a  <= rf_rdata_a;
            alu_b  <= rf_rdata_b;
            alu_op <= op_q;
            state  <= EXEC;
          end
        end
        EXEC: begin
          result_q <= alu_y;
          rf_we    <= 1'b1;
          rf_waddr <= rd_q;
          rf_wdata <= alu_y;
          alu_a    <= '0;
          alu_b    <= '0;
          alu_op   <= '0;
          state    <= WB;
        end
        WB: begin
          rf_waddr <= '0;
          rf_wdata <= '0;
          if (rep_q != 2'd0) begin
            rep_q      <= rep_q - 2'd1;
            rf_raddr_a <= rd_q;
            rf_raddr_b <= rs2_q;
            state      <= READ;
          end else begin
            rsp_valid <= 1'b1;
            rsp_data  <= result_q;
            rsp_zero  <= (result_q == '0);
            state     <= DONE;
          end
        end
        DONE: begin
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            rsp_zero  <= 1'b0;
            cmd_ready <= 1'b1;
            busy      <= 1'b0;
`ifdef ALU_SEQ_ERR_CHK_EN
            err_q     <= 1'b0;
`endif
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_seq_ctrl.sv
// tb_alu_seq_ctrl: directed bench for alu_seq_ctrl with a behavioural
// register file and ALU around the DUT. Honours ALU_SEQ_ERR_CHK_EN.
module tb_alu_seq_ctrl;

  localparam int DW = 8;
  localparam int AW = 2;

  logic          clk = 1'b0;
  logic          rst;
  logic          cmd_valid;
  logic          cmd_ready;
  logic [2:0]    cmd_op;
  logic [AW-1:0] cmd_rd, cmd_rs1, cmd_rs2;
  logic [1:0]    cmd_rep;
  logic [AW-1:0] rf_raddr_a, rf_raddr_b;
  logic [DW-1:0] rf_rdata_a, rf_rdata_b;
  logic          rf_we;
  logic [AW-1:0] rf_waddr;
  logic [DW-1:0] rf_wdata;
  logic [DW-1:0] alu_a, alu_b, alu_y;
  logic [2:0]    alu_op;
  logic          rsp_valid, rsp_ready, rsp_zero, rsp_err, busy;
  logic [DW-1:0] rsp_data;

  int vectors = 0;
  int miscompares = 0;

  alu_seq_ctrl #(.DW(DW), .AW(AW)) dut (
    .clk(clk), .rst(rst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
    .cmd_rd(cmd_rd), .cmd_rs1(cmd_rs1), .cmd_rs2(cmd_rs2), .cmd_rep(cmd_rep),
    .rf_raddr_a(rf_raddr_a), .rf_raddr_b(rf_raddr_b),
    .rf_rdata_a(rf_rdata_a), .rf_rdata_b(rf_rdata_b),
    .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata),
    .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op), .alu_y(alu_y),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
    .rsp_zero(rsp_zero), .rsp_err(rsp_err), .busy(busy)
  );

  always #5 clk = ~clk;

  // Register file: preloaded values come from the stimulus, DUT writes
  // override them until the next preload bumps the generation number.
  logic [DW-1:0] pre_rf [4];
  int            pre_gen = 0;
  logic [DW-1:0] wr_rf [4];
  int            wr_gen [4] = '{-1, -1, -1, -1};
  logic [AW-1:0] wr_addr_q [$];
  logic [DW-1:0] wr_data_q [$];

  assign rf_rdata_a = (wr_gen[rf_raddr_a] == pre_gen) ? wr_rf[rf_raddr_a] : pre_rf[rf_raddr_a];
  assign rf_rdata_b = (wr_gen[rf_raddr_b] == pre_gen) ? wr_rf[rf_raddr_b] : pre_rf[rf_raddr_b];

  // Capture every write the DUT commits at a rising edge.
  always @(posedge clk) begin
    if (rf_we) begin
      wr_rf[rf_waddr]  <= rf_wdata;
      wr_gen[rf_waddr] <= pre_gen;
      wr_addr_q.push_back(rf_waddr);
      wr_data_q.push_back(rf_wdata);
    end
  end

  // Behavioural ALU; reserved ops return a recognisable marker.
  always_comb begin
    alu_y = 8'hA5;
    case (alu_op)
      3'd0: alu_y = alu_a + alu_b;
      3'd1: alu_y = alu_a - alu_b;
      3'd2: alu_y = alu_a & alu_b;
      3'd3: alu_y = alu_a | alu_b;
      3'd4: alu_y = alu_a ^ alu_b;
      3'd5: alu_y = alu_a;
      default: alu_y = 8'hA5;
    endcase
  end

  task automatic check_output(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("[TB] FAIL %s: observed %0h, expected %0h", tag, obs, exp);
    end
  endtask

  task automatic preload(input logic [DW-1:0] r0, input logic [DW-1:0] r1);
    pre_gen++;
    pre_rf[0] = r0;
    pre_rf[1] = r1;
    pre_rf[2] = 8'h00;
    pre_rf[3] = 8'h00;
  endtask

  // Present one command at a falling edge; returns just after the accepting edge.
  task automatic apply_stimulus(input logic [2:0] op, input logic [AW-1:0] rd,
                                input logic [AW-1:0] rs1, input logic [AW-1:0] rs2,
                                input logic [1:0] rep);
    @(negedge clk);
    check_output("cmd_ready_before_accept", cmd_ready, 1);
    cmd_op    = op;
    cmd_rd    = rd;
    cmd_rs1   = rs1;
    cmd_rs2   = rs2;
    cmd_rep   = rep;
    cmd_valid = 1'b1;
    @(posedge clk);
    #1;
    cmd_valid = 1'b0;
  endtask

  // Latency counts the accepting edge as 1; a missing response is a failure.
  task automatic wait_rsp(output int lat);
    int n = 0;
    while (!rsp_valid && n < 50) begin
      @(posedge clk);
      #1;
      n++;
    end
    check_output("rsp_valid_within_bound", rsp_valid, 1);
    lat = n + 1;
  endtask

  task automatic finish_rsp();
    rsp_ready = 1'b1;
    @(posedge clk);
    #1;
    rsp_ready = 1'b0;
    check_output("rsp_valid_after_handshake", rsp_valid, 0);
    check_output("busy_after_handshake", busy, 0);
    check_output("cmd_ready_after_handshake", cmd_ready, 1);
  endtask

  initial begin
    int lat;
    int base;
    rst = 1'b1;
    cmd_valid = 1'b0;
    cmd_op = '0; cmd_rd = '0; cmd_rs1 = '0; cmd_rs2 = '0; cmd_rep = '0;
    rsp_ready = 1'b0;
    preload(8'd5, 8'd3);
    repeat (3) @(posedge clk);
    #1;
    check_output("reset_busy", busy, 0);
    check_output("reset_rsp_valid", rsp_valid, 0);
    check_output("reset_rf_we", rf_we, 0);
    @(negedge clk);
    rst = 1'b0;
    #1;
    check_output("post_reset_cmd_ready", cmd_ready, 1);
    check_output("post_reset_rsp_data", rsp_data, 0);
    check_output("post_reset_rsp_zero", rsp_zero, 0);
    check_output("post_reset_rsp_err", rsp_err, 0);

    $display("[TB] ADD r2 = r0(5) + r1(3)");
    base = wr_data_q.size();
    apply_stimulus(3'd0, 2'd2, 2'd0, 2'd1, 2'd0);
    check_output("add_busy", busy, 1);
    check_output("add_cmd_ready_low", cmd_ready, 0);
    wait_rsp(lat);
    check_output("add_latency", lat, 4);
    check_output("add_rsp_data", rsp_data, 8);
    check_output("add_rsp_zero", rsp_zero, 0);
    check_output("add_rsp_err", rsp_err, 0);
    check_output("add_write_count", wr_data_q.size() - base, 1);
    check_output("add_waddr", wr_addr_q[base], 2);
    check_output("add_wdata", wr_data_q[base], 8);
    check_output("done_alu_a_zero", alu_a, 0);
    check_output("done_raddr_a_zero", rf_raddr_a, 0);
    check_output("done_rf_we_low", rf_we, 0);
    finish_rsp();

    $display("[TB] SUB r3 = r0(7) - r1(7)");
    preload(8'd7, 8'd7);
    base = wr_data_q.size();
    apply_stimulus(3'd1, 2'd3, 2'd0, 2'd1, 2'd0);
    wait_rsp(lat);
    check_output("sub_write_count", wr_data_q.size() - base, 1);
    check_output("sub_waddr", wr_addr_q[base], 3);
    check_output("sub_wdata", wr_data_q[base], 0);
    check_output("sub_rsp_data", rsp_data, 0);
    check_output("sub_rsp_zero", rsp_zero, 1);
    finish_rsp();

    $display("[TB] ADD r2 = r0(250) + r1(10), rep 2, with stalled response");
    preload(8'd250, 8'd10);
    base = wr_data_q.size();
    apply_stimulus(3'd0, 2'd2, 2'd0, 2'd1, 2'd2);
    wait_rsp(lat);
    check_output("rep_latency", lat, 10);
    check_output("rep_rsp_data", rsp_data, 24);
    check_output("rep_write_count", wr_data_q.size() - base, 3);
    check_output("rep_wdata0", wr_data_q[base], 4);
    check_output("rep_wdata1", wr_data_q[base+1], 14);
    check_output("rep_wdata2", wr_data_q[base+2], 24);
    check_output("rep_waddr2", wr_addr_q[base+2], 2);
    @(negedge clk);
    cmd_op = 3'd3; cmd_rd = 2'd1; cmd_rs1 = 2'd0; cmd_rs2 = 2'd1; cmd_rep = 2'd0;
    cmd_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk);
      #1;
      check_output("stall_rsp_valid", rsp_valid, 1);
      check_output("stall_rsp_data", rsp_data, 24);
      check_output("stall_cmd_ready", cmd_ready, 0);
    end
    check_output("stall_no_write", wr_data_q.size() - base, 3);
    rsp_ready = 1'b1;
    @(posedge clk);
    #1;
    check_output("stall_release_idle", cmd_ready, 1);
    check_output("stall_release_rsp_valid", rsp_valid, 0);
    rsp_ready = 1'b0;
    @(posedge clk);
    #1;
    cmd_valid = 1'b0;
    check_output("second_cmd_accepted", busy, 1);
    wait_rsp(lat);
    check_output("or_rsp_data", rsp_data, 250);
    check_output("or_waddr", wr_addr_q[base+3], 1);
    finish_rsp();

    $display("[TB] reset pulse during EXEC");
    preload(8'd5, 8'd3);
    base = wr_data_q.size();
    apply_stimulus(3'd0, 2'd2, 2'd0, 2'd1, 2'd0);
    @(posedge clk);
    #2;
    rst = 1'b1;
    #1;
    check_output("exec_rst_busy", busy, 0);
    check_output("exec_rst_rf_we", rf_we, 0);
    check_output("exec_rst_cmd_ready", cmd_ready, 1);
    check_output("exec_rst_alu_a", alu_a, 0);
    @(negedge clk);
    rst = 1'b0;
    repeat (6) @(posedge clk);
    #1;
    check_output("exec_rst_no_write", wr_data_q.size() - base, 0);
    check_output("exec_rst_no_rsp", rsp_valid, 0);

    $display("[TB] reset pulse during WB");
    apply_stimulus(3'd0, 2'd2, 2'd0, 2'd1, 2'd0);
    @(posedge clk);
    @(posedge clk);
    #1;
    check_output("wb_rf_we_high", rf_we, 1);
    rst = 1'b1;
    #1;
    check_output("wb_rst_rf_we", rf_we, 0);
    @(negedge clk);
    rst = 1'b0;
    repeat (6) @(posedge clk);
    #1;
    check_output("wb_rst_no_write", wr_data_q.size() - base, 0);
    check_output("wb_rst_no_rsp", rsp_valid, 0);

    $display("[TB] reserved op 7");
    base = wr_data_q.size();
    apply_stimulus(3'd7, 2'd3, 2'd0, 2'd1, 2'd0);
    wait_rsp(lat);
`ifdef ALU_SEQ_ERR_CHK_EN
    check_output("rsv_latency", lat, 2);
    check_output("rsv_write_count", wr_data_q.size() - base, 0);
    check_output("rsv_rsp_err", rsp_err, 1);
    check_output("rsv_rsp_data", rsp_data, 0);
    check_output("rsv_rsp_zero", rsp_zero, 1);
`else
    check_output("rsv_latency", lat, 4);
    check_output("rsv_write_count", wr_data_q.size() - base, 1);
    check_output("rsv_rsp_err", rsp_err, 0);
    check_output("rsv_rsp_data", rsp_data, 8'hA5);
    check_output("rsv_rsp_zero", rsp_zero, 0);
`endif
    finish_rsp();
    check_output("rsv_rsp_err_cleared", rsp_err, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
